// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle of the branch predictor.
// The slave modport is the predictor; the master modport is the pipeline driving it.
interface branch_predictor_if;
    logic        stall;
    logic        PL_flush;
    logic [31:0] if_pc;
    logic        if_B_type;
    logic        if_jalr;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_B_type;
    logic        ex_jalr;
    logic        ex_taken;
    logic [31:0] ex_jalr_pc_new;
    logic        B_type_prediction_result;
    logic [31:0] jalr_pc_prediciton;
    logic [31:0] br_cnt;
    logic [31:0] mis_cnt;

    modport slave (
        input  stall, PL_flush, if_pc, if_B_type, if_jalr,
        input  ex_valid, ex_pc, ex_B_type, ex_jalr, ex_taken, ex_jalr_pc_new,
        output B_type_prediction_result, jalr_pc_prediciton, br_cnt, mis_cnt
    );

    modport master (
        output stall, PL_flush, if_pc, if_B_type, if_jalr,
        output ex_valid, ex_pc, ex_B_type, ex_jalr, ex_taken, ex_jalr_pc_new,
        input  B_type_prediction_result, jalr_pc_prediciton, br_cnt, mis_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Two-bit-counter direction predictor plus tagged jalr target table, trained from EX,
// with same-cycle update bypass and registered predictions for the ID stage.
module branch_predictor #(
    parameter int unsigned BHT_IDX_W = 6,
    parameter int unsigned JTB_IDX_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    branch_predictor_if.slave   bus
);
    localparam int unsigned BHT_N = 1 << BHT_IDX_W;
    localparam int unsigned JTB_N = 1 << JTB_IDX_W;
    localparam int unsigned TAG_W = 32 - JTB_IDX_W - 2;

    logic [1:0]       bht        [BHT_N];
    logic             jtb_valid  [JTB_N];
    logic [TAG_W-1:0] jtb_tag    [JTB_N];
    logic [31:0]      jtb_target [JTB_N];

    logic             dir_q;
    logic [31:0]      tgt_q;
    logic [31:0]      br_q;
    logic [31:0]      mis_q;

    logic [BHT_IDX_W-1:0] if_bht_idx_c, ex_bht_idx_c;
    logic [JTB_IDX_W-1:0] if_jtb_idx_c, ex_jtb_idx_c;
    logic [TAG_W-1:0]     if_tag_c, ex_tag_c;
    logic                 bht_upd_c, jtb_upd_c;
    logic [1:0]           bht_cur_c, bht_new_c, lookup_ctr_c;
    logic                 jtb_hit_c;
    logic [31:0]          jtb_tgt_c, pred_tgt_c;
    logic                 pred_dir_c;
    logic                 unused_pc_bits_c;

    assign unused_pc_bits_c = ^{bus.ex_pc[1:0]};

    // Index/tag extraction, saturating counter update and bypassed lookup
    always_comb begin
        if_bht_idx_c = bus.if_pc[BHT_IDX_W+1:2];
        ex_bht_idx_c = bus.ex_pc[BHT_IDX_W+1:2];
        if_jtb_idx_c = bus.if_pc[JTB_IDX_W+1:2];
        ex_jtb_idx_c = bus.ex_pc[JTB_IDX_W+1:2];
        if_tag_c     = bus.if_pc[31:JTB_IDX_W+2];
        ex_tag_c     = bus.ex_pc[31:JTB_IDX_W+2];

        bht_upd_c = bus.ex_valid && bus.ex_B_type;
        // A conflicting B_type+jalr resolve only trains the BHT
        jtb_upd_c = bus.ex_valid && bus.ex_jalr && !bus.ex_B_type;

        bht_cur_c = bht[ex_bht_idx_c];
        bht_new_c = bht_cur_c;
        if (bus.ex_taken) begin
            if (bht_cur_c != 2'b11) bht_new_c = bht_cur_c + 2'd1;
        end else begin
            if (bht_cur_c != 2'b00) bht_new_c = bht_cur_c - 2'd1;
        end

        lookup_ctr_c = bht[if_bht_idx_c];
        if (bht_upd_c && (ex_bht_idx_c == if_bht_idx_c)) lookup_ctr_c = bht_new_c;
        pred_dir_c = lookup_ctr_c[1];

        jtb_hit_c = jtb_valid[if_jtb_idx_c] && (jtb_tag[if_jtb_idx_c] == if_tag_c);
        jtb_tgt_c = jtb_target[if_jtb_idx_c];
        if (jtb_upd_c && (ex_jtb_idx_c == if_jtb_idx_c)) begin
            jtb_hit_c = (ex_tag_c == if_tag_c);
            jtb_tgt_c = bus.ex_jalr_pc_new;
        end
        pred_tgt_c = jtb_hit_c ? jtb_tgt_c : (bus.if_pc + 32'd4);
    end

    // Prediction tables; training is independent of stall/flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_N); i++) bht[i] <= 2'b01;
            for (int j = 0; j < int'(JTB_N); j++) begin
                jtb_valid[j]  <= 1'b0;
                jtb_tag[j]    <= '0;
                jtb_target[j] <= 32'd0;
            end
        end else begin
            if (bht_upd_c) bht[ex_bht_idx_c] <= bht_new_c;
            if (jtb_upd_c) begin
                jtb_valid[ex_jtb_idx_c]  <= 1'b1;
                jtb_tag[ex_jtb_idx_c]    <= ex_tag_c;
                jtb_target[ex_jtb_idx_c] <= bus.ex_jalr_pc_new;
            end
        end
    end

    // Prediction output register: flush beats stall beats load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= 1'b0;
            tgt_q <= 32'd0;
        end else if (bus.PL_flush) begin
            dir_q <= 1'b0;
            tgt_q <= 32'd0;
        end else if (!bus.stall) begin
            dir_q <= pred_dir_c && bus.if_B_type;
            tgt_q <= bus.if_jalr ? pred_tgt_c : 32'd0;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_q  <= 32'd0;
            mis_q <= 32'd0;
        end else begin
            if (bus.ex_valid && (bus.ex_B_type || bus.ex_jalr) && (br_q != 32'hFFFF_FFFF))
                br_q <= br_q + 32'd1;
            if (bus.ex_valid && bus.PL_flush && (mis_q != 32'hFFFF_FFFF))
                mis_q <= mis_q + 32'd1;
        end
    end

    assign bus.B_type_prediction_result = dir_q;
    assign bus.jalr_pc_prediciton       = tgt_q;
    assign bus.br_cnt                   = br_q;
    assign bus.mis_cnt                  = mis_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: the driver queues hand-computed
// expectations, a monitor pops and compares them after each rising edge.
module tb_branch_predictor;
    logic clk;
    logic rst_n;
    branch_predictor_if bus();

    branch_predictor #(.BHT_IDX_W(6), .JTB_IDX_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       nm;
        int          due;
        logic        dir;
        logic [31:0] tgt;
        logic [31:0] br;
        logic [31:0] mis;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // staged stimulus, applied at the next falling edge
    logic [31:0] s_ipc = 32'd0;
    logic        s_ib = 1'b0, s_ij = 1'b0;
    logic        s_ev = 1'b0, s_eb = 1'b0, s_ej = 1'b0, s_et = 1'b0;
    logic [31:0] s_epc = 32'd0, s_etgt = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string what, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s %s: got %h, required %h", nm, what, act, req);
        end
    endtask

    task automatic check_out(input string nm, input logic dir, input logic [31:0] tgt,
                             input logic [31:0] br, input logic [31:0] mis);
        cmp(nm, "dir", {31'd0, bus.B_type_prediction_result}, {31'd0, dir});
        cmp(nm, "tgt", bus.jalr_pc_prediciton, tgt);
        cmp(nm, "br_cnt", bus.br_cnt, br);
        cmp(nm, "mis_cnt", bus.mis_cnt, mis);
    endtask

    // Monitor: compare every expectation that has come due on this edge
    always begin
        exp_t e;
        @(posedge clk);
        cyc = cyc + 1;
        #2;
        while (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            check_out(e.nm, e.dir, e.tgt, e.br, e.mis);
        end
    end

    task automatic stage_if(input logic [31:0] pc, input logic b, input logic j);
        s_ipc = pc; s_ib = b; s_ij = j;
    endtask

    task automatic stage_ex(input logic v, input logic [31:0] pc, input logic b, input logic j,
                            input logic t, input logic [31:0] tgt);
        s_ev = v; s_epc = pc; s_eb = b; s_ej = j; s_et = t; s_etgt = tgt;
    endtask

    task automatic issue(input string nm, input logic st, input logic fl, input logic dir,
                         input logic [31:0] tgt, input int br, input int mis);
        exp_t e;
        @(negedge clk);
        bus.stall = st; bus.PL_flush = fl;
        bus.if_pc = s_ipc; bus.if_B_type = s_ib; bus.if_jalr = s_ij;
        bus.ex_valid = s_ev; bus.ex_pc = s_epc; bus.ex_B_type = s_eb; bus.ex_jalr = s_ej;
        bus.ex_taken = s_et; bus.ex_jalr_pc_new = s_etgt;
        e.nm = nm; e.due = cyc + 1; e.dir = dir; e.tgt = tgt;
        e.br = 32'(br); e.mis = 32'(mis);
        q.push_back(e);
        stage_ex(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 8) begin
            @(posedge clk);
            #3;
            k++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations pending, required 0", q.size());
        end
    endtask

    task automatic idle_inputs();
        bus.stall = 1'b0; bus.PL_flush = 1'b0;
        bus.if_pc = 32'd0; bus.if_B_type = 1'b0; bus.if_jalr = 1'b0;
        bus.ex_valid = 1'b0; bus.ex_pc = 32'd0; bus.ex_B_type = 1'b0; bus.ex_jalr = 1'b0;
        bus.ex_taken = 1'b0; bus.ex_jalr_pc_new = 32'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #12;
        check_out("reset", 1'b0, 32'd0, 32'd0, 32'd0);
        rst_n = 1'b1;

        // direction training and saturation at index 0 (pc 0x100)
        stage_if(32'h104, 1, 0); stage_ex(1, 32'h100, 1, 0, 1, 0); issue("train1", 0, 0, 0, 0, 1, 0);
        stage_if(32'h104, 1, 0); stage_ex(1, 32'h100, 1, 0, 1, 0); issue("train2", 0, 0, 0, 0, 2, 0);
        stage_if(32'h104, 1, 0); stage_ex(1, 32'h100, 1, 0, 1, 0); issue("train3", 0, 0, 0, 0, 3, 0);
        stage_if(32'h100, 1, 0);                                   issue("pred_taken", 0, 0, 1, 0, 3, 0);
        stage_if(32'h100, 1, 0); stage_ex(1, 32'h100, 1, 0, 0, 0); issue("nt_bypass10", 0, 0, 1, 0, 4, 0);
        stage_if(32'h100, 1, 0); stage_ex(1, 32'h100, 1, 0, 0, 0); issue("nt_bypass01", 0, 0, 0, 0, 5, 0);
        stage_if(32'h100, 1, 0);                                   issue("pred_nt", 0, 0, 0, 0, 5, 0);

        // jalr target table: fill, hit, alias miss, replacement with bypass
        stage_if(32'h3000, 0, 1); stage_ex(1, 32'h2004, 0, 1, 0, 32'h8000); issue("jtb_cold", 0, 0, 0, 32'h3004, 6, 0);
        stage_if(32'h2004, 0, 1);                                   issue("jtb_hit", 0, 0, 0, 32'h8000, 6, 0);
        stage_if(32'h4004, 0, 1);                                   issue("jtb_alias", 0, 0, 0, 32'h4008, 6, 0);
        stage_if(32'h2004, 0, 0);                                   issue("not_jalr", 0, 0, 0, 32'h0, 6, 0);
        stage_if(32'h4004, 0, 1); stage_ex(1, 32'h4004, 0, 1, 0, 32'h9000); issue("jtb_bypass", 0, 0, 0, 32'h9000, 7, 0);
        stage_if(32'h2004, 0, 1);                                   issue("jtb_replaced", 0, 0, 0, 32'h2008, 7, 0);

        // direction bypass, dual-class resolve, ex_valid gating
        stage_if(32'h40, 1, 0); stage_ex(1, 32'h40, 1, 0, 1, 0);     issue("dir_bypass", 0, 0, 1, 0, 8, 0);
        stage_if(32'h44, 1, 1); stage_ex(1, 32'h44, 1, 1, 1, 32'h7777); issue("both_types", 0, 0, 1, 32'h48, 9, 0);
        stage_if(32'h44, 0, 1);                                     issue("both_no_jtb", 0, 0, 0, 32'h48, 9, 0);
        stage_if(32'h100, 1, 0); stage_ex(0, 32'h100, 1, 0, 1, 0);  issue("ex_invalid", 0, 0, 0, 0, 9, 0);

        // output-register priority: flush > stall > load
        stage_if(32'h40, 1, 1);                                     issue("load", 0, 0, 1, 32'h44, 9, 0);
        stage_if(32'h100, 0, 0);                                    issue("stall1", 1, 0, 1, 32'h44, 9, 0);
        stage_if(32'h3000, 0, 1);                                   issue("stall2", 1, 0, 1, 32'h44, 9, 0);
        stage_if(32'h40, 1, 1); stage_ex(1, 32'h100, 1, 0, 1, 0);   issue("flush_stall", 1, 1, 0, 0, 10, 1);
        stage_if(32'h100, 1, 0);                                    issue("flush_nov", 0, 1, 0, 0, 10, 1);
        stage_if(32'h100, 1, 0);                                    issue("after_flush", 0, 0, 1, 0, 10, 1);
        drain();

        // asynchronous reset between edges, with an update in flight
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        bus.if_pc = 32'h100; bus.if_B_type = 1'b1;
        bus.ex_valid = 1'b1; bus.ex_pc = 32'h100; bus.ex_B_type = 1'b1; bus.ex_taken = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 32'd0, 32'd0, 32'd0);
        @(posedge clk);
        #3;
        idle_inputs();
        rst_n = 1'b1;

        stage_if(32'h40, 1, 0); stage_ex(1, 32'h100, 1, 0, 1, 0);   issue("post_rst_nt", 0, 0, 0, 0, 1, 0);
        stage_if(32'h100, 1, 0);                                    issue("post_rst_upd", 0, 0, 1, 0, 1, 0);
        stage_if(32'h4004, 0, 1);                                   issue("post_rst_jtb", 0, 0, 0, 32'h4008, 1, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter BHT_IDX_W, default 6, sets the BHT index width; the BHT has 2^BHT_IDX_W two-bit counters indexed by pc[BHT_IDX_W+1:2].
REQ-002 Parameter JTB_IDX_W, default 3, sets the jalr target table (JTB) index width; the JTB has 2^JTB_IDX_W entries indexed by pc[JTB_IDX_W+1:2], each holding valid, tag = pc[31:JTB_IDX_W+2] and a 32-bit target.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 stall  in  1  pipeline hold; freezes the registered prediction outputs.
REQ-006 PL_flush  in  1  misprediction flush from the branch judge.
REQ-007 if_pc  in  32  PC of the instruction being fetched.
REQ-008 if_B_type / if_jalr  in  1 each  fetched instruction is a conditional branch / jalr.
REQ-009 ex_valid  in  1  EX stage holds a real (non-bubble) instruction.
REQ-010 ex_pc  in  32  PC of the instruction in EX.
REQ-011 ex_B_type / ex_jalr  in  1 each  EX instruction class.
REQ-012 ex_taken  in  1  resolved direction of the EX branch.
REQ-013 ex_jalr_pc_new  in  32  resolved jalr target.
REQ-014 B_type_prediction_result  out  1  registered predicted direction for the instruction entering ID.
REQ-015 jalr_pc_prediciton  out  32  registered predicted jalr target for the instruction entering ID.
REQ-016 br_cnt / mis_cnt  out  32 each  resolved-control-transfer count / misprediction count.

Function
REQ-017 Lookup is combinational from if_pc: the direction is taken when BHT counter bit[1] = 1; the jalr target is the JTB target on valid && tag match, otherwise if_pc + 4 (modulo 2^32).
REQ-018 A BHT update occurs when ex_valid && ex_B_type: ex_taken=1 increments the counter, saturating at 2'b11; ex_taken=0 decrements it, saturating at 2'b00.
REQ-019 A JTB update occurs when ex_valid && ex_jalr: the entry indexed by ex_pc is written with valid=1, the tag of ex_pc and ex_jalr_pc_new, replacing any previous contents.
REQ-020 Updates are not gated by stall or PL_flush.
REQ-021 Same-cycle bypass: when an update targets the entry being looked up, the lookup returns the post-update value.
REQ-022 Output register priority is PL_flush, then stall, then load.
REQ-023 PL_flush=1: B_type_prediction_result <= 0 and jalr_pc_prediciton <= 0.
REQ-024 stall=1 and PL_flush=0: both outputs hold their values.
REQ-025 Otherwise (load): B_type_prediction_result <= lookup direction && if_B_type, and jalr_pc_prediciton <= lookup target when if_jalr, else 0.
REQ-026 This gives 1-cycle latency from if_pc to the outputs.
REQ-027 br_cnt increments when ex_valid && (ex_B_type || ex_jalr).
REQ-028 mis_cnt increments when ex_valid && PL_flush.
REQ-029 Both counters saturate at 32'hFFFF_FFFF and never wrap.
REQ-030 ex_B_type and ex_jalr are mutually exclusive; if both are 1, only the BHT update is performed.

Reset
REQ-031 While rst_n=0, regardless of clk:
- all BHT counters = 2'b01 (weakly not-taken)
- all JTB valid bits = 0
- B_type_prediction_result = 0
- jalr_pc_prediciton = 0
- br_cnt = 0, mis_cnt = 0
REQ-032 Reset asserted mid-update discards that update; the first update is accepted on the first rising edge after rst_n rises.

Verification
REQ-033 Saturation and direction: reset; resolve branch pc=0x100 taken 3 times -> counter 01->10->11->11; next fetch of 0x100 with if_B_type=1 -> B_type_prediction_result=1 one cycle later; br_cnt=3.
REQ-034 Predict not-taken: from counter 11, resolve pc=0x100 not-taken twice -> counter 01; next lookup predicts 0.
REQ-035 JTB hit/miss/alias: resolve jalr pc=0x2004 target=0x8000 -> fetch 0x2004 predicts 0x8000; fetch 0x4004 (same index, different tag) predicts 0x4008.
REQ-036 Bypass: in the same cycle, EX resolves pc=0x40 taken with counter 01 and IF looks up pc=0x40 -> predicted direction 1.
REQ-037 Output-register priority: stall=1 holds outputs across a changing if_pc; PL_flush=1 together with stall=1 -> outputs 0, and with ex_valid=1 mis_cnt increments by 1.
REQ-038 Reset mid-run: after training, pulse rst_n low asynchronously between edges -> outputs and counters 0 immediately; next lookup of a trained PC predicts not-taken / PC+4.
